// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - two-stage pipelined barrel shifter with sticky and normalise modes
//
// Shifts an operand left, logically right, arithmetically right, or normalises it
// by its leading-zero count. The amount is applied in two halves: the high amount
// bits [AMT_W-1:SPLIT] in stage A, the low bits [SPLIT-1:0] in stage B. Each stage
// is a register slice on a stall-propagating valid/ready pipeline.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   block can accept the beat this cycle
//   in_data    operand (WIDTH bits)
//   in_amt     shift amount (ignored in NORM)
//   in_mode    0=SLL, 1=SRL, 2=SRA, 3=NORM
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_data   shifted result
//   out_sticky OR of all 1-bits shifted out (SRL/SRA only)
//   out_amt    shift actually applied (in_amt, or leading-zero count in NORM)
//   out_zero   operand was all zeros

module barrel_shift_pipe #(
    parameter int WIDTH = 25,
    parameter int AMT_W = 5,
    parameter int SPLIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_zero
);

    localparam logic [1:0] MODE_SLL  = 2'd0;
    localparam logic [1:0] MODE_SRL  = 2'd1;
    localparam logic [1:0] MODE_SRA  = 2'd2;
    localparam logic [1:0] MODE_NORM = 2'd3;

    // One power-of-two shift level. Returns {lost, result}; lost is the OR of
    // the bits pushed off the LSB end (right shifts only). Verilog shifts by
    // s >= WIDTH yield zero, so the masks saturate naturally: an oversized level
    // drops every bit and fills the whole word.
    function automatic logic [WIDTH:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int unsigned      s,
        input logic             right,
        input logic             fill
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] lost_mask;
        ones = '1;
        if (right) begin
            res       = (d >> s) | (fill ? ~(ones >> s) : '0);
            lost_mask = ~(ones << s);
            return {|(d & lost_mask), res};
        end
        return {1'b0, d << s};
    endfunction

    // Leading-zero count; WIDTH for an all-zero operand.
    function automatic logic [AMT_W-1:0] count_lz(input logic [WIDTH-1:0] d);
        logic [AMT_W-1:0] n;
        logic             found;
        n     = AMT_W'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                n     = AMT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Stage A registers
    // ------------------------------------------------------------------
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic [AMT_W-1:0] a_amt;
    logic [1:0]       a_mode;
    logic             a_sticky;
    logic             a_zero;

    // Flow control
    logic b_advance;
    logic a_advance;

    assign b_advance = !out_valid || out_ready;
    assign a_advance = b_advance || !a_valid;
    assign in_ready  = a_advance;

    // ------------------------------------------------------------------
    // Stage A combinational: effective amount and high shift levels
    // ------------------------------------------------------------------
    logic [AMT_W-1:0] a_eff_amt;
    logic [WIDTH-1:0] a_shift;
    logic             a_lost;
    logic             a_right;
    logic             a_fill;
    logic [WIDTH:0]   a_step;

    always_comb begin
        a_eff_amt = (in_mode == MODE_NORM) ? count_lz(in_data) : in_amt;
        a_right   = (in_mode == MODE_SRL) || (in_mode == MODE_SRA);
        a_fill    = (in_mode == MODE_SRA) && in_data[WIDTH-1];
        a_shift   = in_data;
        a_lost    = 1'b0;
        a_step    = '0;
        for (int k = SPLIT; k < AMT_W; k++) begin
            if (a_eff_amt[k]) begin
                a_step  = shift_level(a_shift, 32'd1 << k, a_right, a_fill);
                a_shift = a_step[WIDTH-1:0];
                a_lost  = a_lost | a_step[WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid  <= 1'b0;
            a_data   <= '0;
            a_amt    <= '0;
            a_mode   <= MODE_SLL;
            a_sticky <= 1'b0;
            a_zero   <= 1'b0;
        end else if (a_advance) begin
            a_valid <= in_valid;
            // Payload only captured on a real transfer so idle inputs are ignored.
            if (in_valid) begin
                a_data   <= a_shift;
                a_amt    <= a_eff_amt;
                a_mode   <= in_mode;
                a_sticky <= a_lost;
                a_zero   <= (in_data == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B combinational: low shift levels
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_shift;
    logic             b_lost;
    logic             b_right;
    logic             b_fill;
    logic [WIDTH:0]   b_step;

    always_comb begin
        b_right = (a_mode == MODE_SRL) || (a_mode == MODE_SRA);
        // After any partial arithmetic shift the MSB still carries the sign.
        b_fill  = (a_mode == MODE_SRA) && a_data[WIDTH-1];
        b_shift = a_data;
        b_lost  = 1'b0;
        b_step  = '0;
        for (int k = 0; k < SPLIT; k++) begin
            if (a_amt[k]) begin
                b_step  = shift_level(b_shift, 32'd1 << k, b_right, b_fill);
                b_shift = b_step[WIDTH-1:0];
                b_lost  = b_lost | b_step[WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sticky <= 1'b0;
            out_amt    <= '0;
            out_zero   <= 1'b0;
        end else if (b_advance) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_data   <= b_shift;
                out_sticky <= a_sticky | b_lost;
                out_amt    <= a_amt;
                out_zero   <= a_zero;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - self-checking bench for barrel_shift_pipe
module tb_barrel_shift_pipe;
    localparam int WIDTH = 25;
    localparam int AMT_W = 5;
    localparam int SPLIT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;
    logic [AMT_W-1:0] out_amt;
    logic             out_zero;

    always #5 clk = ~clk;

    barrel_shift_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .SPLIT(SPLIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sticky(out_sticky), .out_amt(out_amt), .out_zero(out_zero)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sticky;
        logic [AMT_W-1:0] amt;
        logic             zero;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;
    bit   rand_bp = 0;
    bit   stall_armed = 0;
    int   stall_cnt = 0;
    int   phase_pops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [WIDTH-1:0] d, input logic s,
                                input logic [AMT_W-1:0] a, input logic z);
        res_t r;
        r.data = d; r.sticky = s; r.amt = a; r.zero = z;
        return r;
    endfunction

    // Reference: arithmetic on 64-bit integers straight from the mode rules.
    function automatic res_t model(input logic [WIDTH-1:0] d, input int amt, input int mode);
        res_t        r;
        longint unsigned v;
        longint unsigned mask;
        longint      sx;
        int          lz;
        v    = 64'(d);
        mask = (64'd1 << WIDTH) - 1;
        r.zero = (d == 0);
        r.amt  = AMT_W'(amt);
        r.sticky = 1'b0;
        case (mode)
            0: r.data = (amt >= WIDTH) ? '0 : WIDTH'((v << amt) & mask);
            1: begin
                r.data   = (amt >= WIDTH) ? '0 : WIDTH'(v >> amt);
                r.sticky = (amt >= WIDTH) ? (v != 0) : ((v & ((64'd1 << amt) - 1)) != 0);
            end
            2: begin
                sx       = d[WIDTH-1] ? longint'(v | ~mask) : longint'(v);
                r.data   = WIDTH'(sx >>> amt);
                r.sticky = (amt >= WIDTH) ? (v != 0) : ((v & ((64'd1 << amt) - 1)) != 0);
            end
            default: begin
                lz = 0;
                while (lz < WIDTH && ((v >> (WIDTH - 1 - lz)) & 1) == 0) lz++;
                r.data = WIDTH'((v << lz) & mask);
                r.amt  = AMT_W'(lz);
            end
        endcase
        return r;
    endfunction

    task automatic send(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                        input logic [1:0] m, input res_t e);
        int guard;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
        #2;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic send_rand();
        logic [WIDTH-1:0] d;
        logic [AMT_W-1:0] a;
        logic [1:0]       m;
        d = WIDTH'($urandom);
        if ($urandom_range(0, 2) == 0) d = d >> $urandom_range(0, WIDTH);
        a = AMT_W'($urandom);
        m = 2'($urandom);
        send(d, a, m, model(d, (m == 2'd3) ? 0 : int'(a), int'(m)));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_amt   = AMT_W'($urandom);
        in_mode  = 2'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: drives out_ready, checks results, stability and in_ready.
    initial begin
        res_t             e;
        logic [WIDTH-1:0] held;
        bit               holding;
        holding = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                holding = 0;
                continue;
            end
            if (stall_armed && out_valid && phase_pops == 1) begin
                stall_cnt   = 3;
                stall_armed = 0;
            end
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (rand_bp) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (holding) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(held));
            end
            check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(out_data), 64'(e.data));
                    check("sticky", 64'(out_sticky), 64'(e.sticky));
                    check("amt", 64'(out_amt), 64'(e.amt));
                    check("zero", 64'(out_zero), 64'(e.zero));
                end
                phase_pops++;
                holding = 0;
            end else if (out_valid) begin
                holding = 1;
                held = out_data;
            end else begin
                holding = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sticky", 64'(out_sticky), 64'd0);
        check("rst_out_amt", 64'(out_amt), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1;

        // Directed vectors with hand-derived results
        send(25'h0000001, 5'd24, 2'd0, mk(25'h1000000, 1'b0, 5'd24, 1'b0));
        send(25'h0000001, 5'd25, 2'd0, mk(25'h0000000, 1'b0, 5'd25, 1'b0));
        send(25'h1000003, 5'd1,  2'd1, mk(25'h0800001, 1'b1, 5'd1,  1'b0));
        send(25'h1000003, 5'd31, 2'd1, mk(25'h0000000, 1'b1, 5'd31, 1'b0));
        send(25'h1000000, 5'd4,  2'd1, mk(25'h0100000, 1'b0, 5'd4,  1'b0));
        send(25'h1000000, 5'd4,  2'd2, mk(25'h1F00000, 1'b0, 5'd4,  1'b0));
        send(25'h1000001, 5'd30, 2'd2, mk(25'h1FFFFFF, 1'b1, 5'd30, 1'b0));
        send(25'h0000100, 5'd3,  2'd3, mk(25'h1000000, 1'b0, 5'd16, 1'b0));
        send(25'h0000000, 5'd7,  2'd3, mk(25'h0000000, 1'b0, 5'd25, 1'b1));
        send(25'h1800000, 5'd9,  2'd3, mk(25'h1800000, 1'b0, 5'd0,  1'b0));
        send(25'h0000000, 5'd3,  2'd2, mk(25'h0000000, 1'b0, 5'd3,  1'b1));
        send(25'h1FFFFFF, 5'd25, 2'd2, mk(25'h1FFFFFF, 1'b1, 5'd25, 1'b0));
        idle();
        drain();

        // Six back-to-back beats with a three-cycle stall on the second result
        phase_pops = 0;
        stall_armed = 1;
        repeat (6) send_rand();
        idle();
        drain();
        check("stall_seen", 64'(stall_armed), 64'd0);

        // Random traffic with random backpressure and idle gaps
        rand_bp = 1;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();
        drain();
        rand_bp = 0;

        // Reset with two beats in flight
        @(posedge clk);
        #2;
        mon_en = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 25'h0000005; in_amt = 5'd1; in_mode = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_data = 25'h0000009;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 25'h1000003; in_amt = 5'd1; in_mode = 2'd1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_empty", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_edge1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", 64'(out_valid), 64'd1);
        check("lat_data", 64'(out_data), 64'h0800001);
        check("lat_sticky", 64'(out_sticky), 64'd1);
        @(posedge clk);
        #1;
        check("lat_single", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
